// File: rtl/tiny_risc_controller.sv
// Tiny RISC control unit: fetch/decode/execute FSM with memory wait-state timeout fault.
// Optional single-step mode (HOLD state, step/halted ports) is enabled by defining SINGLE_STEP_EN.
module tiny_risc_controller #(
   parameter int WAIT_LIMIT = 15,
   parameter int WCNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op_code,
   input  logic       mem_ready,
`ifdef SINGLE_STEP_EN
   input  logic       step,
   output logic       halted,
`endif
   output logic       ir_on_adr,
   output logic       pc_on_adr,
   output logic       dbus_on_data,
   output logic       data_on_dbus,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       clr_pc,
   output logic       pass,
   output logic       add,
   output logic       alu_on_dbus,
   output logic       read_mem,
   output logic       write_mem,
   output logic       instr_done,
   output logic       fault
);

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_STA = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_FAULT  = 3'd4
`ifdef SINGLE_STEP_EN
      , ST_HOLD = 3'd5
`endif
   } state_t;

   state_t            state_reg, state_next;
   logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
   logic              exec_done;
   logic              mem_wait;

   // JMP never touches memory, so it retires regardless of mem_ready.
   assign exec_done = (state_reg == ST_EXEC) && ((op_code == OP_JMP) || mem_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_RST;
         wcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wcnt_next  = '0;
      mem_wait   = 1'b0;
      case (state_reg)
         ST_RST:    state_next = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) state_next = ST_DECODE;
            else           mem_wait   = 1'b1;
         end
         ST_DECODE: state_next = ST_EXEC;
         ST_EXEC: begin
            if (exec_done) begin
`ifdef SINGLE_STEP_EN
               state_next = ST_HOLD;
`else
               state_next = ST_FETCH;
`endif
            end else begin
               mem_wait = 1'b1;
            end
         end
         ST_FAULT:  state_next = ST_FAULT;
`ifdef SINGLE_STEP_EN
         ST_HOLD: if (step) state_next = ST_FETCH;
`endif
         default:   state_next = ST_RST;
      endcase
      // A pending access that is still not ready at the limit faults; ready at the limit completes.
      if (mem_wait) begin
         if (wcnt_reg == WCNT_W'(WAIT_LIMIT)) state_next = ST_FAULT;
         else                                 wcnt_next  = wcnt_reg + 1'b1;
      end
   end

   always_comb begin
      ir_on_adr    = 1'b0;
      pc_on_adr    = 1'b0;
      dbus_on_data = 1'b0;
      data_on_dbus = 1'b0;
      ld_ir        = 1'b0;
      ld_ac        = 1'b0;
      ld_pc        = 1'b0;
      inc_pc       = 1'b0;
      clr_pc       = 1'b0;
      pass         = 1'b0;
      add          = 1'b0;
      alu_on_dbus  = 1'b0;
      read_mem     = 1'b0;
      write_mem    = 1'b0;
      instr_done   = 1'b0;
      fault        = 1'b0;
`ifdef SINGLE_STEP_EN
      halted       = 1'b0;
`endif
      case (state_reg)
         ST_RST: clr_pc = 1'b1;
         ST_FETCH: begin
            pc_on_adr    = 1'b1;
            read_mem     = 1'b1;
            data_on_dbus = 1'b1;
            ld_ir        = mem_ready;
         end
         ST_DECODE: inc_pc = 1'b1;
         ST_EXEC: begin
            ir_on_adr  = 1'b1;
            instr_done = exec_done;
            case (op_code)
               OP_LDA: begin
                  read_mem     = 1'b1;
                  data_on_dbus = 1'b1;
                  pass         = 1'b1;
                  ld_ac        = mem_ready;
               end
               OP_STA: begin
                  write_mem    = 1'b1;
                  alu_on_dbus  = 1'b1;
                  dbus_on_data = 1'b1;
               end
               OP_ADD: begin
                  read_mem     = 1'b1;
                  data_on_dbus = 1'b1;
                  add          = 1'b1;
                  ld_ac        = mem_ready;
               end
               default: ld_pc = 1'b1;
            endcase
         end
         ST_FAULT: fault = 1'b1;
`ifdef SINGLE_STEP_EN
         ST_HOLD: halted = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule
